// File: rtl/page_stream_qin_array.sv
// Input-queue bank for a TDF page: NCH independent FWFT FIFOs with registered
// early backpressure, occupancy, sticky overflow and an all-channels-EOS flag.
module page_stream_qin_array #(
  parameter  int NCH   = 8,
  parameter  int W     = 9,
  parameter  int DEPTH = 4,
  parameter  int SLACK = 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*W-1:0]  in_d,
  input  logic [NCH-1:0]    in_e,
  input  logic [NCH-1:0]    in_v,
  output logic [NCH-1:0]    in_b,
  output logic [NCH*W-1:0]  out_d,
  output logic [NCH-1:0]    out_e,
  output logic [NCH-1:0]    out_v,
  input  logic [NCH-1:0]    out_b,
  output logic [NCH*LW-1:0] level,
  output logic [NCH-1:0]    ovf,
  output logic              all_eos,
  input  logic              eos_clr
);

  localparam int              PW     = $clog2(DEPTH);
  localparam logic [LW-1:0]   C_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]   C_THR  = LW'(DEPTH - SLACK);

  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_eos_pop;
  logic [NCH-1:0] w_eos_next;
  logic [NCH-1:0] r_eos_seen;
  logic           r_all_eos;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [LW-1:0] r_cnt;
    logic          r_inb;
    logic          r_ovf;
    logic [LW-1:0] w_cnt_next;
    logic [W:0]    w_head;
    logic          w_nonempty;
    logic          w_full;
    logic          w_push;

    assign w_head     = r_mem[r_rp];
    assign w_nonempty = (r_cnt != '0);
    assign w_full     = (r_cnt == C_FULL);
    assign w_pop[i]   = w_nonempty & ~out_b[i];
    // A full queue still accepts a token when its head leaves on the same edge.
    assign w_push     = in_v[i] & (~w_full | w_pop[i]);
    assign w_cnt_next = r_cnt + LW'(w_push) - LW'(w_pop[i]);
    assign w_eos_pop[i] = w_pop[i] & w_head[W];

    always_ff @(posedge clock) begin
      if (!reset) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_inb <= 1'b1;
        r_ovf <= 1'b0;
      end else begin
        if (w_push)   r_wp <= r_wp + PW'(1);
        if (w_pop[i]) r_rp <= r_rp + PW'(1);
        r_cnt <= w_cnt_next;
        r_inb <= (w_cnt_next >= C_THR);
        if (in_v[i] & ~w_push) r_ovf <= 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (reset && w_push) r_mem[r_wp] <= {in_e[i], in_d[i*W +: W]};
    end

    assign out_v[i]          = w_nonempty;
    assign out_d[i*W +: W]   = w_nonempty ? w_head[W-1:0] : '0;
    assign out_e[i]          = w_nonempty & w_head[W];
    assign level[i*LW +: LW] = r_cnt;
    assign in_b[i]           = r_inb;
    assign ovf[i]            = r_ovf;
  end

  // An EOS pop on the clearing edge still marks its channel as seen.
  assign w_eos_next = (r_eos_seen & ~{NCH{eos_clr}}) | w_eos_pop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_eos_seen <= '0;
      r_all_eos  <= 1'b0;
    end else begin
      r_eos_seen <= w_eos_next;
      r_all_eos  <= &w_eos_next;
    end
  end

  assign all_eos = r_all_eos;

endmodule

// File: tb/tb_page_stream_qin_array.sv
// Bench for page_stream_qin_array: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_page_stream_qin_array;
  localparam int NCH = 8, W = 9, DEPTH = 4, SLACK = 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH*W-1:0]  in_d;
  logic [NCH-1:0]    in_e, in_v, in_b;
  logic [NCH*W-1:0]  out_d;
  logic [NCH-1:0]    out_e, out_v, out_b;
  logic [NCH*LW-1:0] level;
  logic [NCH-1:0]    ovf;
  logic              all_eos, eos_clr;

  page_stream_qin_array #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clock(clock), .reset(reset), .in_d(in_d), .in_e(in_e), .in_v(in_v),
    .in_b(in_b), .out_d(out_d), .out_e(out_e), .out_v(out_v), .out_b(out_b),
    .level(level), .ovf(ovf), .all_eos(all_eos), .eos_clr(eos_clr)
  );

  always #5 clock = ~clock;

  // Reference model: one queue of {eos, data} per channel.
  logic [W:0]     mq [NCH][$];
  logic [NCH-1:0] m_ovf, m_seen, m_inb;
  logic           m_all;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0]    ev, ee;
    logic [NCH*W-1:0]  ed;
    logic [NCH*LW-1:0] el;
    ev = '0; ee = '0; ed = '0; el = '0;
    for (int c = 0; c < NCH; c++) begin
      el[c*LW +: LW] = LW'(mq[c].size());
      if (mq[c].size() > 0) begin
        ev[c]         = 1'b1;
        ee[c]         = mq[c][0][W];
        ed[c*W +: W]  = mq[c][0][W-1:0];
      end
    end
    chk("out_v", 128'(out_v), 128'(ev));
    chk("out_d", 128'(out_d), 128'(ed));
    chk("out_e", 128'(out_e), 128'(ee));
    chk("level", 128'(level), 128'(el));
    chk("in_b", 128'(in_b), 128'(m_inb));
    chk("ovf", 128'(ovf), 128'(m_ovf));
    chk("all_eos", 128'(all_eos), 128'(m_all));
  endtask

  // Advance the model with the current inputs, clock the DUT, then compare.
  task automatic tick();
    for (int c = 0; c < NCH; c++) begin
      if (!reset) begin
        mq[c].delete();
        m_ovf[c]  = 1'b0;
        m_seen[c] = 1'b0;
        m_inb[c]  = 1'b1;
      end else begin
        bit full, pop, head_e;
        full   = (mq[c].size() == DEPTH);
        pop    = (mq[c].size() > 0) && !out_b[c];
        head_e = 1'b0;
        if (pop) begin
          head_e = mq[c][0][W];
          void'(mq[c].pop_front());
        end
        if (in_v[c]) begin
          if (full && !pop) m_ovf[c] = 1'b1;
          else mq[c].push_back({in_e[c], in_d[c*W +: W]});
        end
        m_inb[c]  = (mq[c].size() >= DEPTH - SLACK);
        m_seen[c] = (m_seen[c] && !eos_clr) || (pop && head_e);
      end
    end
    m_all = reset ? (&m_seen) : 1'b0;
    @(posedge clock);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] ch_d(input int c);
    return out_d[c*W +: W];
  endfunction

  function automatic logic [LW-1:0] ch_l(input int c);
    return level[c*LW +: LW];
  endfunction

  initial begin
    reset = 1'b0; in_d = '0; in_e = '0; in_v = '0; out_b = '1; eos_clr = 1'b0;
    m_ovf = '0; m_seen = '0; m_inb = '1; m_all = 1'b0;

    // Reset and release
    tick(); tick();
    chk("rst_in_b", 128'(in_b), 128'(8'hFF));
    chk("rst_level", 128'(level), 128'(0));
    reset = 1'b1;
    tick();
    chk("rel_in_b", 128'(in_b), 128'(0));

    // Channel 3 fill into overflow
    for (int k = 0; k < 5; k++) begin
      in_v = 8'h08;
      in_d[3*W +: W] = W'(9'h101 + k);
      tick();
      chk("c3_level", 128'(ch_l(3)), 128'((k < 4) ? k + 1 : 4));
      chk("c3_in_b", 128'(in_b[3]), 128'(k >= 2));
      chk("c3_ovf", 128'(ovf[3]), 128'(k == 4));
    end

    // Full channel 3 with simultaneous push and pop across pointer wrap
    out_b = 8'hF7;
    for (int k = 0; k < 8; k++) begin
      chk("c3_head", 128'(ch_d(3)), 128'((k < 4) ? 9'h101 + k : 9'h102 + k));
      in_d[3*W +: W] = W'(9'h106 + k);
      tick();
      chk("c3_lvl_full", 128'(ch_l(3)), 128'(4));
    end
    in_v = '0;
    repeat (5) tick();
    chk("c3_ovf_sticky", 128'(ovf[3]), 128'(1));

    // Channel 0 fall-through latency
    out_b = 8'hFE;
    in_v = 8'h01; in_d[0 +: W] = 9'h1FF;
    tick();
    chk("c0_v", 128'(out_v[0]), 128'(1));
    chk("c0_d", 128'(ch_d(0)), 128'(9'h1FF));
    in_v = '0;
    tick();
    chk("c0_v_pop", 128'(out_v[0]), 128'(0));

    // All-channel EOS
    out_b = '1;
    in_v = '1; in_e = '1;
    for (int c = 0; c < NCH; c++) in_d[c*W +: W] = W'($urandom);
    tick();
    in_v = '0; in_e = '0;
    for (int c = 0; c < NCH; c++) begin
      out_b = ~(8'h01 << c);
      tick();
      chk("all_eos_step", 128'(all_eos), 128'(c == NCH - 1));
    end
    out_b = '1;
    tick(); tick();
    chk("all_eos_hold", 128'(all_eos), 128'(1));
    eos_clr = 1'b1;
    tick();
    eos_clr = 1'b0;
    chk("all_eos_clr", 128'(all_eos), 128'(0));

    // Reset with tokens queued on channel 5
    in_v = 8'h20;
    for (int k = 0; k < 3; k++) begin
      in_d[5*W +: W] = W'(9'h050 + k);
      tick();
    end
    chk("c5_lvl3", 128'(ch_l(5)), 128'(3));
    in_v = '0; reset = 1'b0;
    tick();
    chk("c5_rst_lvl", 128'(ch_l(5)), 128'(0));
    chk("c5_rst_v", 128'(out_v[5]), 128'(0));
    reset = 1'b1;
    in_v = 8'h20; in_d[5*W +: W] = 9'h0AA;
    tick();
    in_v = '0;
    chk("c5_new_v", 128'(out_v[5]), 128'(1));
    chk("c5_new_d", 128'(ch_d(5)), 128'(9'h0AA));

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      in_v  = NCH'($urandom);
      in_e  = NCH'($urandom & $urandom & $urandom);
      out_b = NCH'($urandom);
      for (int c = 0; c < NCH; c++) in_d[c*W +: W] = W'($urandom);
      eos_clr = ($urandom_range(0, 15) == 0);
      reset   = !($urandom_range(0, 199) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
